// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing generator.
// Holds the 640x480@60 default timing constants, the coordinate width, the largest legal
// axis total and the phase type each timing axis decodes its count into.
package video_timing_pkg;

   // 640x480@60 (25.175 MHz pixel clock) defaults
   localparam int unsigned DefHActive = 640;
   localparam int unsigned DefHFp     = 16;
   localparam int unsigned DefHSync   = 96;
   localparam int unsigned DefHBp     = 48;
   localparam int unsigned DefVActive = 480;
   localparam int unsigned DefVFp     = 10;
   localparam int unsigned DefVSync   = 2;
   localparam int unsigned DefVBp     = 33;

   // Coordinates leave the block at a fixed width; no axis total may exceed MaxTotal
   localparam int unsigned CoordW   = 12;
   localparam int unsigned MaxTotal = 4095;

   // Phase order along each axis: Active, then front porch, sync and back porch
   typedef enum logic [1:0] {
      PhActive,
      PhFront,
      PhSync,
      PhBack
   } axis_phase_e;

endpackage

// File: rtl/video_timing_generator_timing_axis.sv
// timing_axis: one counting axis (horizontal or vertical) of the video timing generator.
// Ports:
//   clk   - pixel clock
//   rst   - asynchronous active-low reset, clears the count
//   en    - global count enable
//   step  - advance request (1 for the horizontal axis, horizontal wrap for the vertical)
//   count - current position, 0..TOTAL-1
//   phase - Active / front porch / sync / back porch decode of count
//   wrap  - count is at TOTAL-1; the next step returns it to 0
module timing_axis
   import video_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = DefHActive,
   parameter int unsigned FP     = DefHFp,
   parameter int unsigned SYNC   = DefHSync,
   parameter int unsigned BP     = DefHBp,
   localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
   localparam int unsigned CW    = $clog2(TOTAL)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          step,
   output logic [CW-1:0] count,
   output axis_phase_e   phase,
   output logic          wrap
);

   // A zero front or back porch is legal (that phase is simply skipped); zero active or sync
   // widths would leave the sink without a picture or without a sync edge.
   if (ACTIVE == 0) begin : g_bad_active
      $error("timing_axis: ACTIVE must be non-zero");
   end
   if (SYNC == 0) begin : g_bad_sync
      $error("timing_axis: SYNC must be non-zero");
   end
   if (TOTAL > MaxTotal) begin : g_bad_total
      $error("timing_axis: ACTIVE+FP+SYNC+BP must not exceed 4095");
   end

   logic [CW-1:0] count_q, count_d;
   int unsigned   cnt;

   // Compare in 32 bits: the sync end boundary can equal TOTAL, which may not fit in CW bits
   assign cnt   = 32'(count_q);
   assign wrap  = (cnt == TOTAL - 1);
   assign count = count_q;

   always_comb begin
      count_d = wrap ? '0 : count_q + CW'(1);
   end

   always_comb begin
      phase = PhBack;
      if (cnt < ACTIVE) begin
         phase = PhActive;
      end else if (cnt < ACTIVE + FP) begin
         phase = PhFront;
      end else if (cnt < ACTIVE + FP + SYNC) begin
         phase = PhSync;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (en && step) begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/video_timing_generator.sv
// video_timing_generator: raster timing for a DVI/HDMI transmitter.
// Two timing_axis instances count pixels and lines; every output is registered from the
// counter values, so outputs on cycle n+1 describe the position held on cycle n.
// Ports:
//   clk, rst          - pixel clock, asynchronous active-low reset
//   en                - count enable; when low all state and outputs hold
//   de                - data enable (both axes in their active phase)
//   ctrl0             - {vsync, hsync} for the blue channel encoder
//   ctrl1, ctrl2      - unused control pairs, tied low
//   x, y              - active pixel column / line, 0 outside the active area
//   line_start        - pulse at pixel 0 of every line
//   frame_start       - pulse at pixel 0 of line 0
module video_timing_generator
   import video_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = DefHActive,
   parameter int unsigned H_FP      = DefHFp,
   parameter int unsigned H_SYNC    = DefHSync,
   parameter int unsigned H_BP      = DefHBp,
   parameter int unsigned V_ACTIVE  = DefVActive,
   parameter int unsigned V_FP      = DefVFp,
   parameter int unsigned V_SYNC    = DefVSync,
   parameter int unsigned V_BP      = DefVBp,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              de,
   output logic [1:0]        ctrl0,
   output logic [1:0]        ctrl1,
   output logic [1:0]        ctrl2,
   output logic [CoordW-1:0] x,
   output logic [CoordW-1:0] y,
   output logic              line_start,
   output logic              frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HCW     = $clog2(H_TOTAL);
   localparam int unsigned VCW     = $clog2(V_TOTAL);

   logic [HCW-1:0] h_cnt;
   logic [VCW-1:0] v_cnt;
   axis_phase_e    h_phase, v_phase;
   logic           h_wrap;
   logic           unused_v_wrap;

   timing_axis #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .step  (1'b1),
      .count (h_cnt),
      .phase (h_phase),
      .wrap  (h_wrap)
   );

   // Lines advance only on the edge where the pixel counter wraps
   timing_axis #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .step  (h_wrap),
      .count (v_cnt),
      .phase (v_phase),
      .wrap  (unused_v_wrap)
   );

   logic              de_d, de_q;
   logic              hsync_d, hsync_q;
   logic              vsync_d, vsync_q;
   logic [CoordW-1:0] x_d, x_q;
   logic [CoordW-1:0] y_d, y_q;
   logic              line_start_d, line_start_q;
   logic              frame_start_d, frame_start_q;

   always_comb begin
      de_d          = (h_phase == PhActive) && (v_phase == PhActive);
      hsync_d       = (h_phase == PhSync) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = (v_phase == PhSync) ? VSYNC_POL : ~VSYNC_POL;
      x_d           = de_d ? CoordW'(h_cnt) : '0;
      y_d           = de_d ? CoordW'(v_cnt) : '0;
      line_start_d  = (h_cnt == '0);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
   end

   // Output registers share the counters' enable so a stall freezes (and stretches) everything
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         de_q          <= 1'b0;
         hsync_q       <= ~HSYNC_POL;
         vsync_q       <= ~VSYNC_POL;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (en) begin
         de_q          <= de_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign de          = de_q;
   assign ctrl0       = {vsync_q, hsync_q};
   assign ctrl1       = 2'b00;
   assign ctrl2       = 2'b00;
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule
